chrono_counter: RTL
===================

CHRONO_COUNTER -- requirements
Module: chrono_counter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock for all state) and reset input 1 (synchronous, active-high; sampled on rising clk).
REQ-002 The block SHALL have parameter TICKS_PER_MS, default 50000, meaning clk cycles per millisecond (legal range ≥2).
REQ-003 The block SHALL have input start_stop, 1 bit: single-cycle pulse that toggles run/pause.
REQ-004 The block SHALL have input clear, 1 bit: single-cycle pulse that zeroes the time and returns to idle.
REQ-005 The block SHALL have input lap, 1 bit: single-cycle pulse that toggles the lap (display freeze) function.
REQ-006 The block SHALL have output bin_h, 7 bits: displayed hours, 0..99.
REQ-007 The block SHALL have output bin_min, 6 bits: displayed minutes, 0..59.
REQ-008 The block SHALL have output bin_s, 6 bits: displayed seconds, 0..59.
REQ-009 The block SHALL have output bin_ms, 10 bits: displayed milliseconds, 0..999.
REQ-010 The block SHALL have output running, 1 bit: high when in state RUN.
REQ-011 The block SHALL have output lap_active, 1 bit: high while the displayed time is frozen.
REQ-012 The block SHALL have output overflow, 1 bit: high once the count has saturated at 99:59:59.999.

Function
REQ-013 States SHALL be IDLE, RUN and PAUSED.
REQ-014 Transitions SHALL be:
- IDLE -start_stop-> RUN
- RUN -start_stop-> PAUSED
- PAUSED -start_stop-> RUN
- any state -clear-> IDLE
REQ-015 If clear and start_stop are asserted in the same cycle, clear SHALL win and start_stop SHALL be ignored.
REQ-016 The prescaler SHALL count 0..TICKS_PER_MS-1 only in RUN, and SHALL generate a ms advance on the cycle where it equals TICKS_PER_MS-1, wrapping to 0.
REQ-017 The prescaler SHALL hold its value in PAUSED, so sub-ms phase is preserved, and SHALL be zeroed by clear or reset.
REQ-018 Live count cascade on each ms advance:
- ms 999->0 with carry to s
- s 59->0 with carry to min
- min 59->0 with carry to h
- all carries applied in the same clk edge
REQ-019 At 99:59:59.999, a ms advance SHALL NOT change the count, and overflow SHALL go high and stay high until clear or reset.
REQ-020 While overflow is high in RUN, the prescaler MAY continue but the count SHALL remain saturated.
REQ-021 When lap_active=0, the bin_* outputs SHALL equal the live count registers, with no added latency beyond the counter register.
REQ-022 A lap pulse in RUN with lap_active=0 SHALL copy the live count into the lap registers on that edge and set lap_active=1, while the live count keeps running.
REQ-023 A lap pulse with lap_active=1, in RUN or PAUSED, SHALL clear lap_active, and the outputs SHALL show the live count from the next cycle.
REQ-024 A lap pulse in IDLE, or in PAUSED with lap_active=0, SHALL be ignored.
REQ-025 When lap_active=1, the bin_* outputs SHALL equal the lap registers.
REQ-026 If lap coincides with the ms advance, the lap registers SHALL capture the pre-advance value.
REQ-027 If lap coincides with clear, clear SHALL win: lap_active=0 and all counts 0.
REQ-028 If lap coincides with start_stop, both SHALL take effect independently.
REQ-029 A start_stop held high for multiple cycles SHALL toggle on every cycle it is high, because the pulse shaping is done upstream.
REQ-030 All outputs SHALL be registered, or be muxes of registers, with no combinational path from the inputs to the outputs.

Reset
REQ-031 On reset=1 at a rising clk edge, the block SHALL enter state IDLE.
REQ-032 On reset, the live count, lap registers and prescaler SHALL all be cleared to 0.
REQ-033 On reset, the outputs SHALL be bin_h=0, bin_min=0, bin_s=0, bin_ms=0, running=0, lap_active=0 and overflow=0.
REQ-034 Reset SHALL take priority over every other input, including mid-count and during lap.

Verification (TICKS_PER_MS=4)
REQ-035 Basic counting: reset, then a start_stop pulse, then run 4000 cycles -> bin_s=1, bin_ms=0, running=1.
REQ-036 Pause behaviour: run 10 cycles, start_stop, idle 100 cycles, start_stop, run 6 cycles -> bin_ms=4, with the prescaler phase preserved across the pause.
REQ-037 Cascade boundary: preload the live count to 00:59:59.999 via a test hook (or run to it), then one ms advance -> 01:00:00.000 on that single edge.
REQ-038 Saturation: drive the count to 99:59:59.999 and apply a further ms advance -> the count holds, overflow=1, and overflow stays 1; then a clear pulse -> all outputs 0 and state IDLE.
REQ-039 Lap: at 00:00:01.500 apply a lap pulse and run 2000 cycles -> outputs hold 1.500 with lap_active=1; a second lap pulse -> outputs show 00:00:02.000 on the next cycle.
REQ-040 Simultaneous inputs and reset priority: clear+start_stop in RUN -> IDLE with running=0 and count 0; reset asserted mid-count with lap_active=1 -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/chrono_counter_if.sv
// Control and display bundle for the stopwatch.
// The preload fields are a test hook that lets a bench jump the live count
// straight to a boundary value instead of running for hours of simulated time.
interface chrono_counter_if;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic       preload;
  logic [6:0] preload_h;
  logic [5:0] preload_min;
  logic [5:0] preload_s;
  logic [9:0] preload_ms;
  logic [6:0] bin_h;
  logic [5:0] bin_min;
  logic [5:0] bin_s;
  logic [9:0] bin_ms;
  logic       running;
  logic       lap_active;
  logic       overflow;

  modport master (
    output start_stop, clear, lap, preload, preload_h, preload_min, preload_s, preload_ms,
    input  bin_h, bin_min, bin_s, bin_ms, running, lap_active, overflow
  );

  modport slave (
    input  start_stop, clear, lap, preload, preload_h, preload_min, preload_s, preload_ms,
    output bin_h, bin_min, bin_s, bin_ms, running, lap_active, overflow
  );
endinterface

// File: rtl/chrono_counter.sv
// Stopwatch: run/pause/clear control, millisecond prescaler, a cascaded
// h:min:s.ms counter that saturates at 99:59:59.999, and a lap freeze.
module chrono_counter #(
  parameter int TICKS_PER_MS = 50000
) (
  input logic             clk,
  input logic             reset,
  chrono_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  localparam int             PW        = $clog2(TICKS_PER_MS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_MS - 1);

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] presc;
  logic [6:0]    h;
  logic [5:0]    min;
  logic [5:0]    s;
  logic [9:0]    ms;
  logic [6:0]    lap_h;
  logic [5:0]    lap_min;
  logic [5:0]    lap_s;
  logic [9:0]    lap_ms;
  logic          lap_active;
  logic          overflow;
  logic          advance;
  logic          ms_wrap;
  logic          s_wrap;
  logic          min_wrap;
  logic          at_max;

  assign advance  = (state == RUN) && (presc == PRESC_MAX);
  assign ms_wrap  = (ms == 10'd999);
  assign s_wrap   = (s == 6'd59);
  assign min_wrap = (min == 6'd59);
  assign at_max   = ms_wrap && s_wrap && min_wrap && (h == 7'd99);

  // State register for the run/pause controller.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; clear beats start_stop, a held start_stop toggles every cycle.
  always_comb begin
    state_next = state;
    if (bus.clear) begin
      state_next = IDLE;
    end else if (bus.start_stop) begin
      case (state)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSED;
        PAUSED:  state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Prescaler only moves while running, so a pause keeps the sub-ms phase.
  always_ff @(posedge clk) begin
    if (reset || bus.clear)  presc <= '0;
    else if (state == RUN)   presc <= advance ? '0 : presc + PW'(1);
  end

  // Live count: all carries resolve on one edge, and the top value is sticky.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      h        <= '0;
      min      <= '0;
      s        <= '0;
      ms       <= '0;
      overflow <= 1'b0;
    end else if (bus.preload) begin
      h   <= bus.preload_h;
      min <= bus.preload_min;
      s   <= bus.preload_s;
      ms  <= bus.preload_ms;
    end else if (advance) begin
      if (at_max) begin
        overflow <= 1'b1;
      end else begin
        ms <= ms_wrap ? 10'd0 : ms + 10'd1;
        if (ms_wrap)                      s   <= s_wrap ? 6'd0 : s + 6'd1;
        if (ms_wrap && s_wrap)            min <= min_wrap ? 6'd0 : min + 6'd1;
        if (ms_wrap && s_wrap && min_wrap) h  <= h + 7'd1;
      end
    end
  end

  // Lap freeze: first pulse while running snapshots the pre-advance count,
  // the next pulse (running or paused) releases the display.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      lap_active <= 1'b0;
      lap_h      <= '0;
      lap_min    <= '0;
      lap_s      <= '0;
      lap_ms     <= '0;
    end else if (bus.lap) begin
      if (lap_active) begin
        lap_active <= 1'b0;
      end else if (state == RUN) begin
        lap_active <= 1'b1;
        lap_h      <= h;
        lap_min    <= min;
        lap_s      <= s;
        lap_ms     <= ms;
      end
    end
  end

  assign bus.bin_h      = lap_active ? lap_h   : h;
  assign bus.bin_min    = lap_active ? lap_min : min;
  assign bus.bin_s      = lap_active ? lap_s   : s;
  assign bus.bin_ms     = lap_active ? lap_ms  : ms;
  assign bus.running    = (state == RUN);
  assign bus.lap_active = lap_active;
  assign bus.overflow   = overflow;

endmodule
